// File: rtl/arm7tdmi_mem_stage.sv
// Memory-access stage: one req/ack bus transaction per load/store, registered writeback.
// Optional build macro ARM7TDMI_MEM_TIMEOUT_EN aborts a transaction left unacknowledged for TIMEOUT_CYCLES.
module arm7tdmi_mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic        ex_mem_req,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_mem_size,
    input  logic [31:0] ex_address,
    input  logic [31:0] ex_store_data,
    input  logic [31:0] ex_result,
    input  logic [3:0]  ex_rd,
    input  logic        ex_reg_we,
    output logic        stall_out,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_abort,
    input  logic [31:0] bus_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [3:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        data_abort
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  size_q;
    logic [3:0]  rd_q;
    logic        capture;
    logic        timeout;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] load_fmt;
    logic [63:0] rdata_dbl;
    logic        wb_valid_next;
    logic        wb_we_next;
    logic [3:0]  wb_addr_next;
    logic [31:0] wb_data_next;
    logic        abort_next;

    // Handshake: bus_req stays high with addr/we/be/wdata frozen until a cycle with bus_ack;
    // that cycle ends the transaction, and bus_abort/bus_rdata are only meaningful in it.
    assign bus_req   = (state == REQ);
    assign stall_out = (state == REQ);

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = ex_store_data;
        case (ex_mem_size)
            2'b00: begin
                be_calc    = 4'b0001 << ex_address[1:0];
                wdata_calc = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                be_calc    = ex_address[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{ex_store_data[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = ex_store_data;
            end
        endcase
    end

    // Misaligned word loads rotate right by the byte offset, as on the ARM7.
    assign rdata_dbl = {bus_rdata, bus_rdata} >> {bus_addr[1:0], 3'b000};

    always_comb begin
        load_fmt = rdata_dbl[31:0];
        case (size_q)
            2'b00:   load_fmt = {24'h0, rdata_dbl[7:0]};
            2'b01:   load_fmt = bus_addr[1] ? {16'h0, bus_rdata[31:16]} : {16'h0, bus_rdata[15:0]};
            default: load_fmt = rdata_dbl[31:0];
        endcase
    end

`ifdef ARM7TDMI_MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;

    assign timeout = (state == REQ) && !bus_ack && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || state != REQ) begin
            tmo_cnt <= '0;
        end else if (!bus_ack) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    // No counter in this build; REQ waits for bus_ack indefinitely.
    assign timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_next    = state;
        capture       = 1'b0;
        wb_valid_next = 1'b0;
        wb_we_next    = 1'b0;
        wb_addr_next  = 4'h0;
        wb_data_next  = 32'h0;
        abort_next    = 1'b0;
        case (state)
            IDLE: begin
                if (ex_valid && !flush) begin
                    if (ex_mem_req) begin
                        capture    = 1'b1;
                        state_next = REQ;
                    end else begin
                        wb_valid_next = 1'b1;
                        wb_we_next    = ex_reg_we;
                        wb_addr_next  = ex_rd;
                        wb_data_next  = ex_result;
                    end
                end
            end
            REQ: begin
                if (bus_ack) begin
                    state_next = IDLE;
                    if (bus_abort) begin
                        abort_next = 1'b1;
                    end else begin
                        wb_valid_next = 1'b1;
                        wb_we_next    = !bus_we;
                        wb_addr_next  = rd_q;
                        wb_data_next  = bus_we ? 32'h0 : load_fmt;
                    end
                end else if (timeout) begin
                    state_next = IDLE;
                    abort_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bus_we     <= 1'b0;
            bus_addr   <= 32'h0;
            bus_be     <= 4'h0;
            bus_wdata  <= 32'h0;
            size_q     <= 2'b00;
            rd_q       <= 4'h0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_addr    <= 4'h0;
            wb_data    <= 32'h0;
            data_abort <= 1'b0;
        end else begin
            state      <= state_next;
            wb_valid   <= wb_valid_next;
            wb_we      <= wb_we_next;
            wb_addr    <= wb_addr_next;
            wb_data    <= wb_data_next;
            data_abort <= abort_next;
            if (capture) begin
                bus_we    <= ex_mem_write;
                bus_addr  <= ex_address;
                bus_be    <= be_calc;
                bus_wdata <= wdata_calc;
                size_q    <= ex_mem_size;
                rd_q      <= ex_rd;
            end
        end
    end

endmodule

// File: tb/tb_arm7tdmi_mem_stage.sv
// Directed bench for arm7tdmi_mem_stage: vector table plus hand-written multi-cycle sequences.
module tb_arm7tdmi_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_mem_req = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic [1:0]  ex_mem_size = 2'b00;
    logic [31:0] ex_address = 32'h0;
    logic [31:0] ex_store_data = 32'h0;
    logic [31:0] ex_result = 32'h0;
    logic [3:0]  ex_rd = 4'h0;
    logic        ex_reg_we = 1'b0;
    logic        stall_out;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic        bus_abort = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        wb_valid;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        data_abort;

    int n_total = 0;
    int n_pass  = 0;

    arm7tdmi_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid),
        .ex_mem_req(ex_mem_req), .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size),
        .ex_address(ex_address), .ex_store_data(ex_store_data), .ex_result(ex_result),
        .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .stall_out(stall_out), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_abort(bus_abort), .bus_rdata(bus_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .data_abort(data_abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mem_req;
        logic        write;
        logic [1:0]  size;
        logic [31:0] address;
        logic [31:0] sdata;
        logic [31:0] result;
        logic [3:0]  rd;
        logic        reg_we;
        logic        flush;
        int          ack_delay;
        logic [31:0] rdata;
        logic        abort;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_wbv;
        logic        e_wbwe;
        logic [31:0] e_wbdata;
        logic        e_abort;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(logic mr, logic wr, logic [1:0] sz, logic [31:0] a, logic [31:0] sd,
                                logic [31:0] res, logic [3:0] rd, logic rwe, logic fl, int dly,
                                logic [31:0] rdat, logic ab, logic [3:0] ebe, logic [31:0] ewd,
                                logic ewbv, logic ewbwe, logic [31:0] ewbd, logic eab);
        vec_t v;
        v.mem_req = mr; v.write = wr; v.size = sz; v.address = a; v.sdata = sd;
        v.result = res; v.rd = rd; v.reg_we = rwe; v.flush = fl; v.ack_delay = dly;
        v.rdata = rdat; v.abort = ab; v.e_be = ebe; v.e_wdata = ewd; v.e_wbv = ewbv;
        v.e_wbwe = ewbwe; v.e_wbdata = ewbd; v.e_abort = eab;
        return v;
    endfunction

    task automatic drive_ex(input logic mr, input logic wr, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] sd, input logic [31:0] res, input logic [3:0] rd,
                            input logic rwe, input logic fl);
        ex_valid = 1'b1; ex_mem_req = mr; ex_mem_write = wr; ex_mem_size = sz;
        ex_address = a; ex_store_data = sd; ex_result = res; ex_rd = rd;
        ex_reg_we = rwe; flush = fl;
    endtask

    task automatic idle_ex();
        ex_valid = 1'b0; ex_mem_req = 1'b0; flush = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int i);
        int stalls;
        @(negedge clk);
        drive_ex(v.mem_req, v.write, v.size, v.address, v.sdata, v.result, v.rd, v.reg_we, v.flush);
        @(negedge clk);
        idle_ex();
        if (v.mem_req && !v.flush) begin
            check($sformatf("v%0d_bus_addr", i), bus_addr, v.address);
            check($sformatf("v%0d_bus_we", i), 32'(bus_we), 32'(v.write));
            check($sformatf("v%0d_bus_be", i), 32'(bus_be), 32'(v.e_be));
            if (v.write) check($sformatf("v%0d_bus_wdata", i), bus_wdata, v.e_wdata);
            stalls = 0;
            for (int k = 1; k <= v.ack_delay; k++) begin
                if (stall_out && bus_req) stalls++;
                if (k == v.ack_delay) begin
                    bus_ack = 1'b1; bus_abort = v.abort; bus_rdata = v.rdata;
                end
                @(negedge clk);
            end
            bus_ack = 1'b0; bus_abort = 1'b0; bus_rdata = 32'h0;
            check($sformatf("v%0d_stall_cycles", i), 32'(stalls), 32'(v.ack_delay));
        end
        check($sformatf("v%0d_bus_req_after", i), 32'(bus_req), 32'h0);
        check($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'(v.e_wbv));
        check($sformatf("v%0d_data_abort", i), 32'(data_abort), 32'(v.e_abort));
        if (v.e_wbv) begin
            check($sformatf("v%0d_wb_we", i), 32'(wb_we), 32'(v.e_wbwe));
            check($sformatf("v%0d_wb_addr", i), 32'(wb_addr), 32'(v.rd));
            if (v.e_wbwe) check($sformatf("v%0d_wb_data", i), wb_data, v.e_wbdata);
        end
        @(negedge clk);
        check($sformatf("v%0d_wb_valid_pulse", i), 32'(wb_valid), 32'h0);
        check($sformatf("v%0d_abort_pulse", i), 32'(data_abort), 32'h0);
    endtask

    initial begin
        int req_cycles;
        vecs[0]  = mk(1, 0, 2'd2, 32'h1002, 32'h0, 32'h0, 4'd5, 0, 0, 3, 32'hAABBCCDD, 0, 4'hF, 32'h0, 1, 1, 32'hCCDDAABB, 0);
        vecs[1]  = mk(1, 1, 2'd0, 32'h2003, 32'h12345678, 32'h0, 4'd6, 0, 0, 1, 32'h0, 0, 4'h8, 32'h78787878, 1, 0, 32'h0, 0);
        vecs[2]  = mk(1, 0, 2'd1, 32'h3002, 32'h0, 32'h0, 4'd7, 0, 0, 2, 32'h8001FFFF, 0, 4'hC, 32'h0, 1, 1, 32'h00008001, 0);
        vecs[3]  = mk(0, 0, 2'd0, 32'h0, 32'h0, 32'h55, 4'd3, 1, 0, 0, 32'h0, 0, 4'h0, 32'h0, 1, 1, 32'h55, 0);
        vecs[4]  = mk(0, 0, 2'd0, 32'h0, 32'h0, 32'h77, 4'd9, 0, 0, 0, 32'h0, 0, 4'h0, 32'h0, 1, 0, 32'h0, 0);
        vecs[5]  = mk(1, 0, 2'd2, 32'h8000, 32'h0, 32'h0, 4'd2, 0, 1, 0, 32'h0, 0, 4'h0, 32'h0, 0, 0, 32'h0, 0);
        vecs[6]  = mk(0, 0, 2'd0, 32'h0, 32'h0, 32'h99, 4'd1, 1, 1, 0, 32'h0, 0, 4'h0, 32'h0, 0, 0, 32'h0, 0);
        vecs[7]  = mk(1, 0, 2'd2, 32'h9000, 32'h0, 32'h0, 4'd4, 0, 0, 2, 32'h12345678, 1, 4'hF, 32'h0, 0, 0, 32'h0, 1);
        vecs[8]  = mk(1, 0, 2'd0, 32'h4001, 32'h0, 32'h0, 4'd8, 0, 0, 1, 32'h11223344, 0, 4'h2, 32'h0, 1, 1, 32'h33, 0);
        vecs[9]  = mk(1, 1, 2'd1, 32'h5001, 32'hABCD1234, 32'h0, 4'd2, 0, 0, 2, 32'h0, 0, 4'h3, 32'h12341234, 1, 0, 32'h0, 0);
        vecs[10] = mk(1, 0, 2'd2, 32'h6003, 32'h0, 32'h0, 4'd10, 0, 0, 1, 32'h11223344, 0, 4'hF, 32'h0, 1, 1, 32'h22334411, 0);
        vecs[11] = mk(1, 1, 2'd3, 32'h7002, 32'hCAFEF00D, 32'h0, 4'd0, 0, 0, 1, 32'h0, 0, 4'hF, 32'hCAFEF00D, 1, 0, 32'h0, 0);
        vecs[12] = mk(1, 1, 2'd0, 32'h2000, 32'h000000AB, 32'h0, 4'd0, 0, 0, 1, 32'h0, 0, 4'h1, 32'hABABABAB, 1, 0, 32'h0, 0);
        vecs[13] = mk(1, 0, 2'd1, 32'h3000, 32'h0, 32'h0, 4'd11, 0, 0, 1, 32'h8001FFFF, 0, 4'h3, 32'h0, 1, 1, 32'h0000FFFF, 0);
        vecs[14] = mk(1, 1, 2'd2, 32'hA000, 32'h13572468, 32'h0, 4'd0, 0, 0, 1, 32'h0, 1, 4'hF, 32'h13572468, 0, 0, 32'h0, 1);
        vecs[15] = mk(1, 0, 2'd0, 32'h4003, 32'h0, 32'h0, 4'd12, 0, 0, 2, 32'h80112233, 0, 4'h8, 32'h0, 1, 1, 32'h80, 0);

        // Clock/reset
        repeat (2) @(negedge clk);
        check("rst_bus_req", 32'(bus_req), 32'h0);
        check("rst_stall", 32'(stall_out), 32'h0);
        check("rst_wb_valid", 32'(wb_valid), 32'h0);
        check("rst_data_abort", 32'(data_abort), 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_be", 32'(bus_be), 32'h0);
        check("rst_wb_data", wb_data, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Pass-through immediately followed by a flushed instruction.
        @(negedge clk);
        drive_ex(0, 0, 2'd0, 32'h0, 32'h0, 32'h55, 4'd3, 1, 0);
        @(negedge clk);
        check("b2b_wb_valid", 32'(wb_valid), 32'h1);
        check("b2b_wb_addr", 32'(wb_addr), 32'h3);
        check("b2b_wb_data", wb_data, 32'h55);
        drive_ex(0, 0, 2'd0, 32'h0, 32'h0, 32'h66, 4'd4, 1, 1);
        @(negedge clk);
        idle_ex();
        check("b2b_flushed_wb_valid", 32'(wb_valid), 32'h0);

        // Next op captured in the writeback cycle of the previous load.
        drive_ex(1, 0, 2'd2, 32'h0100, 32'h0, 32'h0, 4'd5, 0, 0);
        @(negedge clk);
        idle_ex();
        bus_ack = 1'b1; bus_rdata = 32'h00000001;
        @(negedge clk);
        bus_ack = 1'b0;
        check("thru_wb_valid", 32'(wb_valid), 32'h1);
        check("thru_wb_data", wb_data, 32'h1);
        check("thru_idle", 32'(bus_req), 32'h0);
        drive_ex(1, 1, 2'd2, 32'h0200, 32'hFEEDBEEF, 32'h0, 4'd0, 0, 0);
        @(negedge clk);
        idle_ex();
        check("thru_recapture_req", 32'(bus_req), 32'h1);
        check("thru_recapture_addr", bus_addr, 32'h0200);
        check("thru_recapture_wdata", bus_wdata, 32'hFEEDBEEF);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        check("thru_store_wb_valid", 32'(wb_valid), 32'h1);
        check("thru_store_wb_we", 32'(wb_we), 32'h0);

        // Reset in the middle of a transaction.
        @(negedge clk);
        drive_ex(1, 0, 2'd2, 32'h0300, 32'h0, 32'h0, 4'd6, 0, 0);
        @(negedge clk);
        idle_ex();
        @(negedge clk);
        check("midrst_req_before", 32'(bus_req), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_bus_req", 32'(bus_req), 32'h0);
        check("midrst_stall", 32'(stall_out), 32'h0);
        check("midrst_wb_valid", 32'(wb_valid), 32'h0);
        check("midrst_abort", 32'(data_abort), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_after_req", 32'(bus_req), 32'h0);
        check("midrst_after_wb", 32'(wb_valid), 32'h0);

        // Unacknowledged transaction.
        drive_ex(1, 0, 2'd2, 32'h0400, 32'h0, 32'h0, 4'd7, 0, 0);
        @(negedge clk);
        idle_ex();
        req_cycles = 0;
        while (bus_req && req_cycles < 12) begin
            req_cycles++;
            @(negedge clk);
        end
`ifdef ARM7TDMI_MEM_TIMEOUT_EN
        check("tmo_req_cycles", 32'(req_cycles), 32'd4);
        check("tmo_data_abort", 32'(data_abort), 32'h1);
        check("tmo_wb_valid", 32'(wb_valid), 32'h0);
        @(negedge clk);
        check("tmo_abort_pulse", 32'(data_abort), 32'h0);
`else
        check("notmo_req_cycles", 32'(req_cycles), 32'd12);
        check("notmo_abort", 32'(data_abort), 32'h0);
        bus_ack = 1'b1; bus_rdata = 32'h0BADF00D;
        @(negedge clk);
        bus_ack = 1'b0;
        check("notmo_wb_valid", 32'(wb_valid), 32'h1);
        check("notmo_wb_data", wb_data, 32'h0BADF00D);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
